// File: rtl/lift53_pkg.sv
// Shared definitions for the 5/3 lifting engine: flag bit positions, lane
// operating modes and the saturation helper.
package lift53_pkg;

  localparam int FLG_EN   = 0;
  localparam int FLG_STEP = 1;
  localparam int FLG_INV  = 2;

  typedef enum logic [2:0] {
    PASS,
    PRED_F,
    PRED_I,
    UPD_F,
    UPD_I
  } mode_e;

  function automatic mode_e decode_mode(input logic en, input logic step, input logic inv);
    if (!en)   return PASS;
    if (!step) return inv ? PRED_I : PRED_F;
    return inv ? UPD_I : UPD_F;
  endfunction

  // Clamps v into the signed range of a w-bit sample.
  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lift53_par_engine_if.sv
// Stream interface between the line buffers, the lifting engine and the
// result RAM writer. Lane i occupies [i*W +: W] (samples) and [i*FW +: FW] (flags).
interface lift53_par_engine_if #(
  parameter int NCH = 16,
  parameter int W   = 9,
  parameter int FW  = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [NCH*W-1:0]   in_left;
  logic [NCH*W-1:0]   in_sam;
  logic [NCH*W-1:0]   in_right;
  logic [NCH*FW-1:0]  in_flgs;
  logic               out_valid;
  logic               out_ready;
  logic [NCH*W-1:0]   out_res;
  logic [NCH-1:0]     out_ovf;
  logic               out_last;
  logic               out_frame;

  modport master (
    output in_valid, in_left, in_sam, in_right, in_flgs, out_ready,
    input  in_ready, out_valid, out_res, out_ovf, out_last, out_frame
  );

  modport slave (
    input  in_valid, in_left, in_sam, in_right, in_flgs, out_ready,
    output in_ready, out_valid, out_res, out_ovf, out_last, out_frame
  );
endinterface

// File: rtl/lift53_lane.sv
// One lane of the lifting datapath: S1 holds the neighbour sum and mode,
// S2 holds the saturated result. Both stages advance only on i_adv.
module lift53_lane
  import lift53_pkg::*;
#(
  parameter int W  = 9,
  parameter int FW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_adv,
  input  logic signed [W-1:0] i_left,
  input  logic signed [W-1:0] i_sam,
  input  logic signed [W-1:0] i_right,
  input  logic [FW-1:0]       i_flg,
  output logic signed [W-1:0] o_res,
  output logic                o_ovf
);

  localparam logic signed [W+1:0] TWO = 2;

  logic signed [W:0]   r_sum;
  logic signed [W-1:0] r_sam;
  mode_e               r_mode;
  logic signed [W-1:0] r_res;
  logic                r_ovf;

  logic signed [W+1:0] w_sam_x;
  logic signed [W+1:0] w_sum_x;
  logic signed [W+1:0] w_half;
  logic signed [W+1:0] w_quart;
  logic signed [W+1:0] w_raw;
  logic signed [31:0]  w_clamp;

  // Upper flag bits are reserved and deliberately ignored.
  if (FW > 3) begin : g_rsv
    logic w_unused_rsv;
    assign w_unused_rsv = ^i_flg[FW-1:3];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_sam  <= '0;
      r_mode <= PASS;
      r_res  <= '0;
      r_ovf  <= 1'b0;
    end else if (i_adv) begin
      r_sum  <= {i_left[W-1], i_left} + {i_right[W-1], i_right};
      r_sam  <= i_sam;
      r_mode <= decode_mode(i_flg[FLG_EN], i_flg[FLG_STEP], i_flg[FLG_INV]);
      r_res  <= W'(w_clamp);
      r_ovf  <= (w_clamp != 32'(w_raw));
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // latch is inferred for unlisted modes.
  always_comb begin
    w_sam_x = {{2{r_sam[W-1]}}, r_sam};
    w_sum_x = {r_sum[W], r_sum};
    w_half  = w_sum_x >>> 1;
    w_quart = (w_sum_x + TWO) >>> 2;
    w_raw   = w_sam_x;
    case (r_mode)
      PRED_F:  w_raw = w_sam_x - w_half;
      PRED_I:  w_raw = w_sam_x + w_half;
      UPD_F:   w_raw = w_sam_x + w_quart;
      UPD_I:   w_raw = w_sam_x - w_quart;
      default: w_raw = w_sam_x;
    endcase
    w_clamp = sat_clamp(32'(w_raw), W);
  end

  assign o_res = r_res;
  assign o_ovf = r_ovf;

endmodule

// File: rtl/lift53_par_engine.sv
// NCH-lane 5/3 lifting engine with valid/ready handshake, 2-stage pipeline,
// and row/frame position tracking of accepted beats.
module lift53_par_engine
  import lift53_pkg::*;
#(
  parameter int NCH       = 16,
  parameter int W         = 9,
  parameter int FW        = 5,
  parameter int ROW_BEATS = 64,
  parameter int ROWS      = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  lift53_par_engine_if.slave           bus,
  output logic [$clog2(ROW_BEATS)-1:0] beat_cnt,
  output logic [$clog2(ROWS)-1:0]      row_cnt,
  output logic                         busy
);

  localparam int BW = $clog2(ROW_BEATS);
  localparam int RW = $clog2(ROWS);

  logic          r_s1_valid;
  logic          r_s1_last;
  logic          r_s1_frame;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_out_frame;
  logic [BW-1:0] r_beat_cnt;
  logic [RW-1:0] r_row_cnt;

  logic               w_adv;
  logic               w_accept;
  logic               w_row_end;
  logic               w_frame_end;
  logic [NCH*W-1:0]   w_res;
  logic [NCH-1:0]     w_ovf;

  assign w_adv       = !r_out_valid || bus.out_ready;
  // Gating with rst_n keeps the engine from advertising space during reset.
  assign bus.in_ready = rst_n && w_adv && !clr;
  assign w_accept    = bus.in_valid && bus.in_ready;
  assign w_row_end   = (r_beat_cnt == BW'(ROW_BEATS - 1));
  assign w_frame_end = w_row_end && (r_row_cnt == RW'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_frame  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_frame <= 1'b0;
      r_beat_cnt  <= '0;
      r_row_cnt   <= '0;
    end else if (clr) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_frame  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_frame <= 1'b0;
      r_beat_cnt  <= '0;
      r_row_cnt   <= '0;
    end else begin
      if (w_adv) begin
        r_s1_valid  <= w_accept;
        r_s1_last   <= w_accept && w_row_end;
        r_s1_frame  <= w_accept && w_frame_end;
        r_out_valid <= r_s1_valid;
        r_out_last  <= r_s1_last;
        r_out_frame <= r_s1_frame;
      end
      if (w_accept) begin
        r_beat_cnt <= w_row_end ? '0 : r_beat_cnt + BW'(1);
        if (w_row_end)
          r_row_cnt <= (r_row_cnt == RW'(ROWS - 1)) ? '0 : r_row_cnt + RW'(1);
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    lift53_lane #(
      .W  (W),
      .FW (FW)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_left  (bus.in_left[g*W +: W]),
      .i_sam   (bus.in_sam[g*W +: W]),
      .i_right (bus.in_right[g*W +: W]),
      .i_flg   (bus.in_flgs[g*FW +: FW]),
      .o_res   (w_res[g*W +: W]),
      .o_ovf   (w_ovf[g])
    );
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_res   = w_res;
  assign bus.out_ovf   = w_ovf;
  assign bus.out_last  = r_out_last;
  assign bus.out_frame = r_out_frame;
  assign beat_cnt      = r_beat_cnt;
  assign row_cnt       = r_row_cnt;
  assign busy          = r_s1_valid || r_out_valid;

endmodule

// File: doc/lift53_par_engine.md
Name: lift53_par_engine

Overview:
- Parametrised successor to the fixed 16-lane, 9-bit parallel lifting datapath.
- Applies one 5/3 integer lifting step (predict or update, forward or inverse) to NCH lanes per beat, selected per lane by a flag field.
- Sits between the left/sample/right line buffers and the result RAM writer.
- Adds a valid/ready stream handshake, a 2-stage pipeline with backpressure, saturation with per-lane overflow, and row/frame position tracking.

Parameters:
- NCH, 16, number of parallel lanes
- W, 9, signed sample width per lane
- FW, 5, flag bits per lane
- ROW_BEATS, 64, accepted beats per row
- ROWS, 64, rows per frame

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush of pipeline and counters
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat
- in_left  in  NCH*W  left neighbours; lane i at [i*W +: W], signed
- in_sam  in  NCH*W  centre samples
- in_right  in  NCH*W  right neighbours
- in_flgs  in  NCH*FW  lane i flags at [i*FW +: FW]
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_res  out  NCH*W  lifted results, signed
- out_ovf  out  NCH  per-lane saturation occurred
- out_last  out  1  beat is last of a row
- out_frame  out  1  beat is last of a frame
- beat_cnt  out  $clog2(ROW_BEATS)  input beat index within the row
- row_cnt  out  $clog2(ROWS)  input row index
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (rst_n low, async): out_valid=0, out_res=0, out_ovf=0, out_last=0, out_frame=0, beat_cnt=0, row_cnt=0, busy=0, internal stage valids=0. in_ready=0 while rst_n is low, 1 after release.
- Handshake:
  - Global advance adv = !out_valid | out_ready.
  - in_ready = adv & !clr.
  - Beat accepted when in_valid & in_ready.
  - out_valid, out_res and all sideband outputs hold stable while out_valid & !out_ready.
- Pipeline (all stages move only on adv):
  - S1 registers sum = left + right (W+1 signed), sam, decoded mode and the last/frame tags.
  - S2 registers the result.
  - Latency 2 cycles with out_ready held high; throughput 1 beat/cycle.
- Flag decode per lane:
  - bit0 en: 0 gives pass-through, out_res = sam, ovf = 0.
  - bit1 step: 0 predict, 1 update.
  - bit2 inv: 0 forward, 1 inverse.
  - bits FW-1..3 reserved, ignored.
- Arithmetic, in W+2 signed; >>> is an arithmetic shift (floor):
  - predict fwd: s - (sum>>>1)
  - predict inv: s + (sum>>>1)
  - update fwd: s + ((sum+2)>>>2)
  - update inv: s - ((sum+2)>>>2)
- Saturation: results outside [-2^(W-1), 2^(W-1)-1] clamp to the nearer bound and set that lane's out_ovf for that beat only.
- Counters:
  - beat_cnt increments on each accepted beat and wraps at ROW_BEATS-1.
  - On wrap, row_cnt increments, wrapping at ROWS-1.
  - Beat tagged last when beat_cnt==ROW_BEATS-1 at acceptance; tagged frame when additionally row_cnt==ROWS-1. Tags travel with the data.
- clr (sync):
  - Zeroes stage valids, out_valid and counters next edge.
  - Beats present the same cycle are not accepted (in_ready=0); clr wins over out_ready.
- Reset mid-operation: all in-flight beats are discarded; no partial outputs appear after release.
- busy = S1 valid | out_valid.

Decomposition:
- Package lift53_pkg holds:
  - flag bit index constants FLG_EN=0, FLG_STEP=1, FLG_INV=2
  - mode enum {PASS, PRED_F, PRED_I, UPD_F, UPD_I}
  - saturation helper function
- One sub-module, lift53_lane: purely per-lane S1/S2 arithmetic, instantiated NCH times by generate.
- Handshake and counters stay in the top level.

Test Plan (W=9, NCH=16, ROW_BEATS=4, ROWS=2):
- Predict fwd, lane 0: l=10, r=20, s=100, flags=3'b001, out_ready=1 -> out_res lane0=85, ovf=0, out_valid exactly 2 cycles after acceptance.
- Update: l=5, r=6, s=7 -> fwd (flags 3'b011) gives 10, inv (3'b111) gives 4. Predict fwd with l=-3, r=0, s=0 -> 2 (floor check).
- Saturation:
  - predict inv l=r=s=255 -> 255, ovf=1.
  - predict fwd s=-256, l=r=255 -> -256, ovf=1.
  - next beat with in-range values -> ovf=0.
- Pass-through: flags 5'b11110 (en=0, reserved bits set) with s=-77 -> -77, ovf=0 on all lanes.
- Backpressure: stream 3 beats, drop out_ready for 5 cycles -> in_ready=0 while stalled, outputs held stable, all 3 results delivered in order, none lost or duplicated.
- Counters: 8 consecutive beats -> out_last on beats 3 and 7, out_frame on beat 7 only, beat_cnt/row_cnt back to 0. Then:
  - pulse rst_n low during beat 2 of the next row -> counters 0, out_valid 0, busy 0, no stale beat after release.
  - same for clr, with in_valid=1 in the clr cycle -> that beat is not accepted.
